fpga_io_controller: RTL and testbench

FPGA_IO_CONTROLLER -- requirements
Module: fpga_io_controller

---
 rtl/fpga_io_controller.sv | 156 +++++++++++++++
 tb/tb_fpga_io_controller.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/fpga_io_controller.sv
// Memory-mapped IO page: seven-segment digits, two LED banks, and debounced pushbuttons
// with sticky read-to-clear press events and a maskable level interrupt.
module fpga_io_controller #(
    parameter int NUM_SS          = 8,
    parameter int NUM_PB          = 21,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  cs,
    input  logic                  read_en,
    input  logic [7:0]            addr,
    input  logic [7:0]            din,
    input  logic [NUM_PB-1:0]     pb,
    output logic [7:0]            dout,
    output logic [8*NUM_SS-1:0]   ss,
    output logic [7:0]            left,
    output logic [7:0]            right,
    output logic                  irq
);
    localparam logic [7:0] ADDR_LEFT   = 8'h10;
    localparam logic [7:0] ADDR_RIGHT  = 8'h11;
    localparam logic [7:0] ADDR_CTRL   = 8'h12;
    localparam logic [7:0] ADDR_CODE   = 8'h13;
    localparam logic [7:0] ADDR_EVENT0 = 8'h14;
    localparam logic [7:0] DB_LIMIT    = 8'(DEBOUNCE_CYCLES);

    function automatic logic [7:0] seg_decode(input logic [7:0] v);
        logic [7:0] g;
        case (v)
            8'd0:  g = 8'h3F;
            8'd1:  g = 8'h06;
            8'd2:  g = 8'h5B;
            8'd3:  g = 8'h4F;
            8'd4:  g = 8'h66;
            8'd5:  g = 8'h6D;
            8'd6:  g = 8'h7D;
            8'd7:  g = 8'h07;
            8'd8:  g = 8'h7F;
            8'd9:  g = 8'h6F;
            8'd10: g = 8'h77;
            8'd11: g = 8'h7C;
            8'd12: g = 8'h39;
            8'd13: g = 8'h5E;
            8'd14: g = 8'h79;
            8'd15: g = 8'h71;
            8'd16: g = 8'h76;
            8'd17: g = 8'h3E;
            8'd18: g = 8'h5C;
            8'd19: g = 8'h50;
            default: g = 8'h3F;
        endcase
        return g;
    endfunction

    logic [7:0]        ss_reg [NUM_SS];
    logic [7:0]        left_reg, right_reg, dout_reg;
    logic [1:0]        ctrl_reg;
    logic [NUM_PB-1:0] sync1_reg, sync2_reg, db_reg, db_next, ev_reg, ev_next, rise, clr;
    logic [7:0]        cnt_reg  [NUM_PB];
    logic [7:0]        cnt_next [NUM_PB];
    logic [31:0]       ev_word;
    logic [7:0]        pb_code, rd_data;
    logic              wr_acc, rd_acc;

    assign wr_acc = cs & ~read_en;
    assign rd_acc = cs & read_en;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PB; gi++) begin : g_pb
            logic differs, hit;
            assign differs       = sync2_reg[gi] ^ db_reg[gi];
            assign hit           = differs && ((cnt_reg[gi] + 8'd1) == DB_LIMIT);
            assign cnt_next[gi]  = (differs && !hit) ? cnt_reg[gi] + 8'd1 : 8'd0;
            assign db_next[gi]   = db_reg[gi] ^ hit;
            assign rise[gi]      = hit & ~db_reg[gi];
            // A rise on the clearing edge wins so the event is never lost.
            assign clr[gi]       = rd_acc && (addr == ADDR_EVENT0 + 8'(gi / 8));
            assign ev_next[gi]   = (ev_reg[gi] & ~clr[gi]) | rise[gi];
        end
        for (gi = 0; gi < NUM_SS; gi++) begin : g_ss
            assign ss[8*gi +: 8] = ss_reg[gi];
        end
    endgenerate

    always_comb begin
        ev_word = '0;
        ev_word[NUM_PB-1:0] = ev_reg;
    end

    always_comb begin
        pb_code = 8'h00;
        for (int i = NUM_PB - 1; i >= 0; i--) begin
            if (db_reg[i]) pb_code = 8'(i + 1);
        end
    end

    always_comb begin
        rd_data = 8'h00;
        for (int i = 0; i < NUM_SS; i++) begin
            if (addr == 8'(i)) rd_data = ss_reg[i];
        end
        case (addr)
            ADDR_LEFT:   rd_data = left_reg;
            ADDR_RIGHT:  rd_data = right_reg;
            ADDR_CTRL:   rd_data = {6'b0, ctrl_reg};
            ADDR_CODE:   rd_data = pb_code;
            8'h14:       rd_data = ev_word[7:0];
            8'h15:       rd_data = ev_word[15:8];
            8'h16:       rd_data = ev_word[23:16];
            8'h17:       rd_data = ev_word[31:24];
            default:     ;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < NUM_SS; i++) ss_reg[i] <= 8'h3F;
            left_reg  <= 8'h00;
            right_reg <= 8'h00;
            ctrl_reg  <= 2'b00;
            dout_reg  <= 8'h00;
            sync1_reg <= '0;
            sync2_reg <= '0;
            db_reg    <= '0;
            ev_reg    <= '0;
            for (int i = 0; i < NUM_PB; i++) cnt_reg[i] <= 8'd0;
        end else begin
            for (int i = 0; i < NUM_SS; i++) begin
                if (wr_acc && addr == 8'(i))
                    ss_reg[i] <= ctrl_reg[0] ? din : seg_decode(din);
            end
            if (wr_acc) begin
                case (addr)
                    ADDR_LEFT:  left_reg  <= din;
                    ADDR_RIGHT: right_reg <= din;
                    ADDR_CTRL:  ctrl_reg  <= din[1:0];
                    default:    ;
                endcase
            end
            if (rd_acc) dout_reg <= rd_data;
            sync1_reg <= pb;
            sync2_reg <= sync1_reg;
            db_reg    <= db_next;
            ev_reg    <= ev_next;
            for (int i = 0; i < NUM_PB; i++) cnt_reg[i] <= cnt_next[i];
        end
    end

    assign dout  = dout_reg;
    assign left  = left_reg;
    assign right = right_reg;
    assign irq   = ctrl_reg[1] & (|ev_reg);

endmodule

// File: tb/tb_fpga_io_controller.sv
// Randomized scoreboard bench for fpga_io_controller against a cycle-level behavioural model.
module tb_fpga_io_controller;
    localparam int NUM_SS = 8;
    localparam int NUM_PB = 21;
    localparam int D      = 4;

    logic                clk = 1'b0;
    logic                nrst, cs, read_en;
    logic [7:0]          addr, din, dout, left, right;
    logic [NUM_PB-1:0]   pb;
    logic [8*NUM_SS-1:0] ss;
    logic                irq;

    int checks = 0;
    int errors = 0;

    fpga_io_controller #(.NUM_SS(NUM_SS), .NUM_PB(NUM_PB), .DEBOUNCE_CYCLES(D)) dut (
        .clk(clk), .nrst(nrst), .cs(cs), .read_en(read_en), .addr(addr), .din(din),
        .pb(pb), .dout(dout), .ss(ss), .left(left), .right(right), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state
    logic [7:0] hex_tab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                 8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
    logic [7:0] m_ss [NUM_SS];
    logic [7:0] m_left, m_right;
    logic [1:0] m_ctrl;
    bit         m_s1 [NUM_PB];
    bit         m_s2 [NUM_PB];
    bit         m_db [NUM_PB];
    int         m_streak [NUM_PB];
    bit [31:0]  m_ev;
    logic [7:0] exp_q [$];

    function automatic logic [7:0] glyph(input logic [7:0] v);
        if (v < 8'd16) return hex_tab[int'(v)];
        case (v)
            8'd16: return 8'h76;
            8'd17: return 8'h3E;
            8'd18: return 8'h5C;
            8'd19: return 8'h50;
            default: return 8'h3F;
        endcase
    endfunction

    function automatic logic [7:0] m_read(input logic [7:0] a);
        int ai = int'(a);
        if (ai < NUM_SS) return m_ss[ai];
        if (ai == 'h10) return m_left;
        if (ai == 'h11) return m_right;
        if (ai == 'h12) return {6'b0, m_ctrl};
        if (ai == 'h13) begin
            for (int k = 0; k < NUM_PB; k++) if (m_db[k]) return 8'(k + 1);
            return 8'h00;
        end
        if (ai >= 'h14 && ai <= 'h17) return m_ev[8*(ai-'h14) +: 8];
        return 8'h00;
    endfunction

    always @(posedge clk or negedge nrst) begin
        bit [31:0] clr_mask;
        bit [31:0] new_ev;
        if (!nrst) begin
            for (int i = 0; i < NUM_SS; i++) m_ss[i] = 8'h3F;
            m_left = 0; m_right = 0; m_ctrl = 0; m_ev = 0;
            for (int k = 0; k < NUM_PB; k++) begin
                m_s1[k] = 0; m_s2[k] = 0; m_db[k] = 0; m_streak[k] = 0;
            end
            exp_q.delete();
        end else begin
            clr_mask = 0;
            new_ev   = 0;
            if (cs && read_en) begin
                exp_q.push_back(m_read(addr));
                if (addr >= 8'h14 && addr <= 8'h17) clr_mask = 32'hFF << (8 * (int'(addr) - 'h14));
            end
            if (cs && !read_en) begin
                if (int'(addr) < NUM_SS) m_ss[int'(addr)] = m_ctrl[0] ? din : glyph(din);
                else if (addr == 8'h10) m_left = din;
                else if (addr == 8'h11) m_right = din;
                else if (addr == 8'h12) m_ctrl = din[1:0];
            end
            // Debounced level flips after D consecutive disagreeing synchronised samples.
            for (int k = 0; k < NUM_PB; k++) begin
                if (m_s2[k] != m_db[k]) begin
                    m_streak[k]++;
                    if (m_streak[k] == D) begin
                        m_db[k] = !m_db[k];
                        m_streak[k] = 0;
                        if (m_db[k]) new_ev[k] = 1'b1;
                    end
                end else begin
                    m_streak[k] = 0;
                end
                m_s2[k] = m_s1[k];
                m_s1[k] = pb[k];
            end
            m_ev = (m_ev & ~clr_mask) | new_ev;
        end
    end

    // Monitor: every cycle compare visible outputs; pop a read expectation when one is due.
    always @(negedge clk) begin
        logic [8*NUM_SS-1:0] exp_ss;
        for (int i = 0; i < NUM_SS; i++) exp_ss[8*i +: 8] = m_ss[i];
        chk("ss", 64'(ss), 64'(exp_ss));
        chk("left", 64'(left), 64'(m_left));
        chk("right", 64'(right), 64'(m_right));
        chk("irq", 64'(irq), 64'(m_ctrl[1] & (|m_ev)));
        if (exp_q.size() > 0) chk("dout", 64'(dout), 64'(exp_q.pop_front()));
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        cs = 1; read_en = 0; addr = a; din = d;
        cyc();
        cs = 0;
    endtask

    task automatic rd(input logic [7:0] a);
        cs = 1; read_en = 1; addr = a;
        cyc();
        cs = 0; read_en = 0;
    endtask

    initial begin
        nrst = 0; cs = 0; read_en = 0; addr = 0; din = 0; pb = '0;
        repeat (3) cyc();
        chk("rst_dout", 64'(dout), 64'h00);
        chk("rst_ss", 64'(ss), 64'h3F3F3F3F3F3F3F3F);
        chk("rst_irq", 64'(irq), 64'h0);
        @(negedge clk);
        nrst = 1;
        cyc();

        wr(8'h02, 8'h05); chk("dec5", 64'(ss[23:16]), 64'h6D);
        wr(8'h02, 8'h2A); chk("dec2a", 64'(ss[23:16]), 64'h3F);
        wr(8'h02, 8'h13); chk("dec13", 64'(ss[23:16]), 64'h50);

        wr(8'h12, 8'h01);
        wr(8'h07, 8'hA5); chk("raw7", 64'(ss[63:56]), 64'hA5);
        rd(8'h07);        chk("rd7", 64'(dout), 64'hA5);

        wr(8'h11, 8'h11); chk("right", 64'(right), 64'h11);
        chk("left_keep", 64'(left), 64'h00);
        wr(8'h12, 8'h00);

        pb[3] = 1; repeat (D - 1) cyc(); pb[3] = 0;
        repeat (8) cyc();
        rd(8'h14); chk("short_ev", 64'(dout), 64'h00);
        pb[3] = 1; repeat (D + 2) cyc();
        repeat (4) cyc();
        rd(8'h13); chk("code4", 64'(dout), 64'h04);
        rd(8'h14); chk("ev3", 64'(dout), 64'h08);
        pb[3] = 0; repeat (10) cyc();

        wr(8'h12, 8'h02);
        pb[20] = 1; repeat (D + 4) cyc();
        chk("irq_on", 64'(irq), 64'h1);
        rd(8'h16); chk("ev20", 64'(dout), 64'h10);
        chk("irq_off", 64'(irq), 64'h0);
        rd(8'h16); chk("ev20_clr", 64'(dout), 64'h00);
        pb[20] = 0; repeat (10) cyc();

        rd(8'h14);
        pb[0] = 1; repeat (D + 1) cyc();
        rd(8'h14); chk("race_first", 64'(dout), 64'h00);
        rd(8'h14); chk("race_second", 64'(dout), 64'h01);
        pb[0] = 0; repeat (10) cyc();

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                int b = $urandom_range(0, NUM_PB - 1);
                pb[b] = ~pb[b];
            end
            if (n == 1500) begin
                nrst = 0; cyc(); cyc(); nrst = 1;
            end
            case ($urandom_range(0, 3))
                0, 1: cyc();
                2: begin
                    logic [7:0] a, d;
                    a = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 'h18));
                    d = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 21)) : 8'($urandom);
                    wr(a, d);
                end
                default: begin
                    logic [7:0] a;
                    a = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 'h18));
                    rd(a);
                end
            endcase
        end
        repeat (3) cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
